// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulus, wrap/saturate, sync load/clear,
// enable prescaler and a registered terminal-count pulse.
module param_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned PRESCALE  = 1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C  = WIDTH'(RESET_VAL);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    // Reject parameter sets that cannot describe a valid counter
    if (WIDTH < 1 || 64'(MAX_VAL) >= (64'd1 << WIDTH) ||
        RESET_VAL > MAX_VAL || PRESCALE < 1) begin : g_param_check
        $fatal(1, "param_updown_counter: illegal parameter combination");
    end

    logic [PW-1:0]    pre_cnt;
    logic [PW-1:0]    pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             step;

    // Next-state: clr > load > prescaled step > hold; tc only on a boundary step
    always_comb begin
        count_nxt = count;
        pre_nxt   = pre_cnt;
        tc_nxt    = 1'b0;
        step      = 1'b0;
        if (clr) begin
            count_nxt = RESET_C;
            pre_nxt   = '0;
        end else if (load) begin
            count_nxt = (load_val > MAX_C) ? MAX_C : load_val;
            pre_nxt   = '0;
        end else if (en) begin
            if (pre_cnt == PRE_LAST) begin
                pre_nxt = '0;
                step    = 1'b1;
            end else begin
                pre_nxt = pre_cnt + PW'(1);
            end
            if (step) begin
                if (!mode) begin
                    if (count == MAX_C) begin
                        tc_nxt    = 1'b1;
                        count_nxt = SATURATE ? MAX_C : '0;
                    end else begin
                        count_nxt = count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
                        tc_nxt    = 1'b1;
                        count_nxt = SATURATE ? '0 : MAX_C;
                    end else begin
                        count_nxt = count - WIDTH'(1);
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= RESET_C;
            pre_cnt <= '0;
            tc      <= 1'b0;
        end else begin
            count   <= count_nxt;
            pre_cnt <= pre_nxt;
            tc      <= tc_nxt;
        end
    end

    // Bound flags decoded straight from the count register
    always_comb begin
        at_max = (count == MAX_C);
        at_min = (count == '0);
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Table-driven bench for param_updown_counter over four parameter sets.
module tb_param_updown_counter;

    typedef struct {
        int         dut;
        logic       en;
        logic       mode;
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic [3:0] exp_count;
        logic       exp_tc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_v   [4];
    logic       mode_v [4];
    logic       clr_v  [4];
    logic       load_v [4];
    logic [3:0] lv_v   [4];
    logic [3:0] count_v[4];
    logic       tc_v   [4];
    logic       max_v  [4];
    logic       min_v  [4];

    int unsigned maxval [4];
    int unsigned rstval [4];
    vec_t        vecs[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // dut0: defaults (WIDTH 4, wrap at 15)
    param_updown_counter u0 (
        .clk(clk), .reset(reset), .en(en_v[0]), .mode(mode_v[0]), .clr(clr_v[0]),
        .load(load_v[0]), .load_val(lv_v[0]), .count(count_v[0]), .tc(tc_v[0]),
        .at_max(max_v[0]), .at_min(min_v[0]));

    // dut1: modulus 10, non-zero reset value
    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3)) u1 (
        .clk(clk), .reset(reset), .en(en_v[1]), .mode(mode_v[1]), .clr(clr_v[1]),
        .load(load_v[1]), .load_val(lv_v[1]), .count(count_v[1]), .tc(tc_v[1]),
        .at_max(max_v[1]), .at_min(min_v[1]));

    // dut2: saturating, bound 5
    param_updown_counter #(.WIDTH(4), .MAX_VAL(5), .SATURATE(1'b1)) u2 (
        .clk(clk), .reset(reset), .en(en_v[2]), .mode(mode_v[2]), .clr(clr_v[2]),
        .load(load_v[2]), .load_val(lv_v[2]), .count(count_v[2]), .tc(tc_v[2]),
        .at_max(max_v[2]), .at_min(min_v[2]));

    // dut3: prescaler of 3
    param_updown_counter #(.WIDTH(4), .PRESCALE(3)) u3 (
        .clk(clk), .reset(reset), .en(en_v[3]), .mode(mode_v[3]), .clr(clr_v[3]),
        .load(load_v[3]), .load_val(lv_v[3]), .count(count_v[3]), .tc(tc_v[3]),
        .at_max(max_v[3]), .at_min(min_v[3]));

    task automatic add(input int d, input logic e, input logic m, input logic c,
                       input logic l, input logic [3:0] v, input logic [3:0] ec,
                       input logic et);
        vec_t x;
        x.dut = d; x.en = e; x.mode = m; x.clr = c; x.load = l; x.lv = v;
        x.exp_count = ec; x.exp_tc = et;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int d, input logic [3:0] ec,
                         input logic et);
        logic emax;
        logic emin;
        emax = (32'(ec) == maxval[d]);
        emin = (ec == 4'd0);
        n_vec++;
        if (count_v[d] !== ec) begin
            n_err++;
            $display("FAIL %s dut%0d count: got %0d want %0d", name, d, count_v[d], ec);
        end
        if (tc_v[d] !== et) begin
            n_err++;
            $display("FAIL %s dut%0d tc: got %b want %b", name, d, tc_v[d], et);
        end
        if (max_v[d] !== emax) begin
            n_err++;
            $display("FAIL %s dut%0d at_max: got %b want %b", name, d, max_v[d], emax);
        end
        if (min_v[d] !== emin) begin
            n_err++;
            $display("FAIL %s dut%0d at_min: got %b want %b", name, d, min_v[d], emin);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 4; k++) begin
            en_v[k] = 1'b0; mode_v[k] = 1'b0; clr_v[k] = 1'b0;
            load_v[k] = 1'b0; lv_v[k] = 4'd0;
        end
    endtask

    initial begin
        maxval = '{15, 9, 5, 15};
        rstval = '{0, 3, 0, 0};
        idle_all();

        // dut0: 17 up steps, 15 -> 0 wrap pulses tc, then hold
        for (int i = 1; i <= 17; i++)
            add(0, 1, 0, 0, 0, 4'd0, 4'(i % 16), (i == 16));
        add(0, 0, 0, 0, 0, 4'd0, 4'd1, 0);

        // dut1: clr beats load, clamped load, down wrap at 9, up wrap at 9
        add(1, 0, 0, 1, 1, 4'd7, 4'd3, 0);
        add(1, 0, 0, 0, 1, 4'd12, 4'd9, 0);
        add(1, 0, 0, 0, 1, 4'd0, 4'd0, 0);
        for (int i = 1; i <= 11; i++)
            add(1, 1, 1, 0, 0, 4'd0, (i == 1 || i == 11) ? 4'd9 : 4'(10 - i),
                (i == 1 || i == 11));
        add(1, 1, 0, 0, 0, 4'd0, 4'd0, 1);
        add(1, 1, 0, 0, 0, 4'd0, 4'd1, 0);
        add(1, 0, 0, 1, 0, 4'd0, 4'd3, 0);

        // dut2: saturate at 5 (tc each attempt), reverse, saturate at 0
        add(2, 0, 0, 0, 1, 4'd5, 4'd5, 0);
        for (int i = 0; i < 3; i++)
            add(2, 1, 0, 0, 0, 4'd0, 4'd5, 1);
        add(2, 1, 1, 0, 0, 4'd0, 4'd4, 0);
        for (int i = 3; i >= 0; i--)
            add(2, 1, 1, 0, 0, 4'd0, 4'(i), 0);
        add(2, 1, 1, 0, 0, 4'd0, 4'd0, 1);
        add(2, 0, 1, 0, 0, 4'd0, 4'd0, 0);

        // dut3: prescale freeze, mode change mid-prescale, load clears prescaler
        add(3, 1, 0, 0, 0, 4'd0, 4'd0, 0);
        add(3, 0, 0, 0, 0, 4'd0, 4'd0, 0);
        add(3, 0, 0, 0, 0, 4'd0, 4'd0, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd0, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd1, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd1, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd1, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd2, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd2, 0);
        add(3, 1, 1, 0, 0, 4'd0, 4'd2, 0);
        add(3, 1, 1, 0, 0, 4'd0, 4'd1, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd1, 0);
        add(3, 0, 0, 0, 1, 4'd4, 4'd4, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd4, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd4, 0);
        add(3, 1, 0, 0, 0, 4'd0, 4'd5, 0);

        // Asynchronous reset, held across two edges
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check("reset_async", k, 4'(rstval[k]), 1'b0);
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 4; k++) check("reset_held", k, 4'(rstval[k]), 1'b0);
        reset = 1'b1;

        // Apply the vector table
        foreach (vecs[i]) begin
            idle_all();
            en_v[vecs[i].dut]   = vecs[i].en;
            mode_v[vecs[i].dut] = vecs[i].mode;
            clr_v[vecs[i].dut]  = vecs[i].clr;
            load_v[vecs[i].dut] = vecs[i].load;
            lv_v[vecs[i].dut]   = vecs[i].lv;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].dut, vecs[i].exp_count, vecs[i].exp_tc);
        end

        // Mid-count reset with a pending tc: dut1 count 6, dut0 just wrapped
        idle_all();
        load_v[0] = 1'b1; lv_v[0] = 4'd15;
        load_v[1] = 1'b1; lv_v[1] = 4'd6;
        @(posedge clk); #1;
        check("pre_load0", 0, 4'd15, 1'b0);
        check("pre_load1", 1, 4'd6, 1'b0);
        idle_all();
        en_v[0] = 1'b1;
        @(posedge clk); #1;
        check("pending_tc", 0, 4'd0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset0", 0, 4'd0, 1'b0);
        check("mid_reset1", 1, 4'd3, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_all();
        en_v[0] = 1'b1;
        @(posedge clk); #1;
        check("after_reset", 0, 4'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
